// File: rtl/level_bar_matrix_scanner.sv
// Row-scanning red/green LED matrix driver showing NCH levels as side-by-side vertical bar graphs.
// Colour tracks the level: green, yellow (red+green), then blinking red at alarm.
module level_bar_matrix_scanner #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned NCH          = 2,
  parameter int unsigned LVL_W        = 4,
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned WARN_LVL     = 10,
  parameter int unsigned ALARM_LVL    = 13,
  parameter int unsigned BLINK_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*LVL_W-1:0] levels_in,
  input  logic                 level_valid,
  input  logic                 freeze,
  output logic [ROWS-1:0]      row_data,
  output logic [COLS-1:0]      red_column_data,
  output logic [COLS-1:0]      green_column_data,
  output logic                 frame_start,
  output logic [NCH-1:0]       alarm
);

  localparam int unsigned CW = COLS / NCH;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned HW = LVL_W + RW + 1;

  localparam logic [RW-1:0] RowLast   = RW'(ROWS - 1);
  localparam logic [DW-1:0] DivLast   = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_FRAMES - 1);

  logic [DW-1:0]        div_q, div_d;
  logic [RW-1:0]        row_q, row_d;
  logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
  logic                 blink_on_q, blink_on_d;
  logic [NCH*LVL_W-1:0] shadow_q, shadow_d;
  logic [NCH*LVL_W-1:0] disp_q, disp_d;

  logic [ROWS-1:0]      row_data_q, row_data_d;
  logic [COLS-1:0]      red_q, red_d;
  logic [COLS-1:0]      green_q, green_d;
  logic                 fs_q, fs_d;
  logic [NCH-1:0]       alarm_q, alarm_d;

  logic                 capture;
  logic                 boundary;

  // Rounded-up bar height; HW bits are wide enough that the sum never overflows.
  function automatic logic [HW-1:0] bar_height(input logic [LVL_W-1:0] lvl);
    logic [HW-1:0] sum;
    sum = HW'(lvl) * HW'(ROWS) + HW'((2 ** LVL_W) - 1);
    return sum >> LVL_W;
  endfunction

  // Outputs are registered from the pre-edge counters, so the edge with row 0 / div 0
  // is the one that puts row 0 on the pins: that is the frame boundary.
  always_comb begin
    capture  = level_valid & ~freeze;
    boundary = (row_q == '0) && (div_q == '0);

    div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
    row_d = row_q;
    if (div_q == DivLast) begin
      row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
    end

    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (boundary) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    shadow_d = capture ? levels_in : shadow_q;
    disp_d   = boundary ? shadow_d : disp_q;
  end

  always_comb begin
    logic [LVL_W-1:0] lvl;
    logic [31:0]      lvl32;
    logic             lit;

    lvl        = '0;
    lvl32      = '0;
    lit        = 1'b0;
    row_data_d = ~(ROWS'(1) << row_q);
    fs_d       = boundary;
    red_d      = '0;
    green_d    = '0;
    alarm_d    = '0;

    for (int c = 0; c < NCH; c++) begin
      lvl        = disp_d[c*LVL_W +: LVL_W];
      lvl32      = 32'(lvl);
      lit        = HW'(row_q) < bar_height(lvl);
      alarm_d[c] = lvl32 >= ALARM_LVL;
      if (lit) begin
        if (lvl32 >= ALARM_LVL) begin
          red_d[c*CW +: CW] = {CW{blink_on_d}};
        end else begin
          green_d[c*CW +: CW] = {CW{1'b1}};
          if (lvl32 >= WARN_LVL) begin
            red_d[c*CW +: CW] = {CW{1'b1}};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      row_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      shadow_q    <= '0;
      disp_q      <= '0;
      row_data_q  <= '1;
      red_q       <= '0;
      green_q     <= '0;
      fs_q        <= 1'b0;
      alarm_q     <= '0;
    end else begin
      div_q       <= div_d;
      row_q       <= row_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      shadow_q    <= shadow_d;
      disp_q      <= disp_d;
      row_data_q  <= row_data_d;
      red_q       <= red_d;
      green_q     <= green_d;
      fs_q        <= fs_d;
      alarm_q     <= alarm_d;
    end
  end

  assign row_data          = row_data_q;
  assign red_column_data   = red_q;
  assign green_column_data = green_q;
  assign frame_start       = fs_q;
  assign alarm             = alarm_q;

endmodule

// File: tb/tb_level_bar_matrix_scanner.sv
// Directed, table-driven bench for level_bar_matrix_scanner at default parameters.
module tb_level_bar_matrix_scanner;

  localparam int FRAME = 32;
  localparam int SDIV  = 4;
  localparam logic [1:0] CG = 2'b01;  // green
  localparam logic [1:0] CY = 2'b11;  // red + green
  localparam logic [1:0] CR = 2'b10;  // blinking red

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] levels_in;
  logic       level_valid;
  logic       freeze;
  logic [7:0] row_data;
  logic [7:0] red;
  logic [7:0] green;
  logic       frame_start;
  logic [1:0] alarm;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;

  typedef struct {
    logic [3:0] lv0;
    logic [3:0] lv1;
    int         ht0;
    int         ht1;
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] alm;
  } vec_t;

  vec_t vecs[8];
  vec_t v_zero, v6, v11, v_byp, v_1111;

  level_bar_matrix_scanner #(
    .ROWS(8), .COLS(8), .NCH(2), .LVL_W(4), .SCAN_DIV(4),
    .WARN_LVL(10), .ALARM_LVL(13), .BLINK_FRAMES(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .levels_in        (levels_in),
    .level_valid      (level_valid),
    .freeze           (freeze),
    .row_data         (row_data),
    .red_column_data  (red),
    .green_column_data(green),
    .frame_start      (frame_start),
    .alarm            (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, ncyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic goto_pos(input int p);
    while ((ncyc % FRAME) != p) tick();
  endtask

  function automatic void exp_cols(input vec_t v, input int row, input bit ph,
                                   output logic [7:0] r, output logic [7:0] g);
    r = 8'h00;
    g = 8'h00;
    if (row < v.ht0) begin
      g[3:0] = {4{v.c0[0]}};
      r[3:0] = {4{v.c0[1] && (v.c0[0] || ph)}};
    end
    if (row < v.ht1) begin
      g[7:4] = {4{v.c1[0]}};
      r[7:4] = {4{v.c1[1] && (v.c1[0] || ph)}};
    end
  endfunction

  // Frame k (1 = first after reset) has blink phase ON iff (k/2) is even.
  task automatic check_cycle(input vec_t v);
    int off, row, k;
    bit ph;
    logic [7:0] er, eg, erow;
    off  = (ncyc - 1) % FRAME;
    row  = off / SDIV;
    k    = (ncyc - 1) / FRAME + 1;
    ph   = ((k / 2) % 2) == 0;
    erow = ~(8'd1 << row);
    exp_cols(v, row, ph, er, eg);
    chk("row_data", 32'(row_data), 32'(erow));
    chk("red", 32'(red), 32'(er));
    chk("green", 32'(green), 32'(eg));
    chk("frame_start", 32'(frame_start), 32'(off == 0));
    chk("alarm", 32'(alarm), 32'(v.alm));
  endtask

  task automatic scan_frames(input vec_t v, input int n);
    repeat (n * FRAME) begin
      tick();
      check_cycle(v);
    end
  endtask

  task automatic finish_frame(input vec_t v);
    while ((ncyc % FRAME) != 0) begin
      tick();
      check_cycle(v);
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic frz);
    levels_in   = {b, a};
    level_valid = 1'b1;
    freeze      = frz;
    tick();
    level_valid = 1'b0;
    freeze      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b0;
    levels_in   = 8'h00;
    level_valid = 1'b0;
    freeze      = 1'b0;

    // {lv0, lv1, h0, h1, colour0, colour1, alarm}; heights hand-computed.
    vecs[0] = '{4'd6,  4'd0,  3, 0, CG, CG, 2'b00};
    vecs[1] = '{4'd11, 4'd0,  6, 0, CY, CG, 2'b00};
    vecs[2] = '{4'd0,  4'd15, 0, 8, CG, CR, 2'b10};
    vecs[3] = '{4'd1,  4'd9,  1, 5, CG, CG, 2'b00};
    vecs[4] = '{4'd10, 4'd12, 5, 6, CY, CY, 2'b00};
    vecs[5] = '{4'd13, 4'd3,  7, 2, CR, CG, 2'b01};
    vecs[6] = '{4'd15, 4'd15, 8, 8, CR, CR, 2'b11};
    vecs[7] = '{4'd0,  4'd0,  0, 0, CG, CG, 2'b00};
    v_zero  = '{4'd0,  4'd0,  0, 0, CG, CG, 2'b00};
    v6      = '{4'd6,  4'd0,  3, 0, CG, CG, 2'b00};
    v11     = '{4'd11, 4'd0,  6, 0, CY, CG, 2'b00};
    v_byp   = '{4'd1,  4'd9,  1, 5, CG, CG, 2'b00};
    v_1111  = '{4'd11, 4'd11, 6, 6, CY, CY, 2'b00};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_row_data", 32'(row_data), 32'h0000_00FF);
    chk("rst_red", 32'(red), 32'h0);
    chk("rst_green", 32'(green), 32'h0);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    chk("rst_alarm", 32'(alarm), 32'h0);

    // Release: first edge shows row 0 with frame_start, then every 32 cycles
    rst  = 1'b1;
    ncyc = 0;
    scan_frames(v_zero, 2);

    for (int i = 0; i < 8; i++) begin
      goto_pos(12);
      apply(vecs[i].lv0, vecs[i].lv1, 1'b0);
      goto_pos(0);
      scan_frames(vecs[i], 4);
    end

    // Mid-frame change holds until the next frame; freeze ignores the strobe
    goto_pos(12);
    apply(4'd6, 4'd0, 1'b0);
    goto_pos(0);
    scan_frames(v6, 1);
    goto_pos(9);
    apply(4'd11, 4'd0, 1'b0);
    finish_frame(v6);
    scan_frames(v11, 1);
    goto_pos(9);
    apply(4'd6, 4'd0, 1'b1);
    finish_frame(v11);
    scan_frames(v11, 2);

    // Strobe on the boundary edge goes straight to the display
    goto_pos(0);
    levels_in   = {4'd9, 4'd1};
    level_valid = 1'b1;
    tick();
    level_valid = 1'b0;
    check_cycle(v_byp);
    repeat (FRAME - 1) begin
      tick();
      check_cycle(v_byp);
    end

    // Asynchronous reset during row 5
    goto_pos(12);
    apply(4'd11, 4'd11, 1'b0);
    goto_pos(0);
    scan_frames(v_1111, 1);
    goto_pos(21);
    check_cycle(v_1111);
    #2 rst = 1'b0;
    #1;
    chk("arst_row_data", 32'(row_data), 32'h0000_00FF);
    chk("arst_red", 32'(red), 32'h0);
    chk("arst_green", 32'(green), 32'h0);
    chk("arst_frame_start", 32'(frame_start), 32'h0);
    chk("arst_alarm", 32'(alarm), 32'h0);
    @(negedge clk);
    rst  = 1'b1;
    ncyc = 0;
    scan_frames(v_zero, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
